dac_serial_tx: RTL

//  Serial DAC writer: takes a 12-bit sample, frames it as 16 bits and shifts it out MSB-first

---
 rtl/dac_serial_tx_pkg.sv | 26 ++
 rtl/dac_serial_tx_if.sv | 12 +
 rtl/dac_shift_reg16.sv | 22 ++
 rtl/dac_serial_tx.sv | 104 ++++++++++
 4 files changed

// File: rtl/dac_serial_tx_pkg.sv
// Shared types and constants for the serial DAC writer: frame geometry,
// FSM state encoding, DAC power-down encodings and the frame builder.
package dac_serial_tx_pkg;

  localparam int DATA_W  = 12;
  localparam int FRAME_W = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    SHIFT = 2'b01,
    DONE  = 2'b10
  } state_t;

  typedef enum logic [1:0] {
    PD_NORMAL = 2'b00,
    PD_1K     = 2'b01,
    PD_100K   = 2'b10,
    PD_HIZ    = 2'b11
  } pd_mode_t;

  // Frame layout: leading zeros, power-down bits, then the sample, MSB first.
  function automatic logic [FRAME_W-1:0] build_frame(pd_mode_t pd, logic [DATA_W-1:0] d);
    return {{(FRAME_W-DATA_W-2){1'b0}}, 2'(pd), d};
  endfunction

endpackage

// File: rtl/dac_serial_tx_if.sv
// Request/serial-output bundle between a sample producer and dac_serial_tx.
interface dac_serial_tx_if import dac_serial_tx_pkg::*; ();
  logic              inicio;
  logic [DATA_W-1:0] dato_in;
  logic              datoDAC;
  logic              CS_out;
  logic              ocupado;
  logic              listo;

  modport master (output inicio, dato_in, input datoDAC, CS_out, ocupado, listo);
  modport slave  (input inicio, dato_in, output datoDAC, CS_out, ocupado, listo);
endinterface

// File: rtl/dac_shift_reg16.sv
// Parallel-load, shift-left register; the MSB flop drives the serial line.
module dac_shift_reg16 #(
  parameter int W = 16
) (
  input  logic         clock44kHz,
  input  logic         reset,
  input  logic         load,
  input  logic         shift,
  input  logic [W-1:0] din,
  output logic         msb
);
  logic [W-1:0] sr;

  // Shifting in zeros leaves the line low once the last bit has gone out.
  always_ff @(posedge clock44kHz or posedge reset) begin
    if (reset)      sr <= '0;
    else if (load)  sr <= din;
    else if (shift) sr <= {sr[W-2:0], 1'b0};
  end

  assign msb = sr[W-1];
endmodule

// File: rtl/dac_serial_tx.sv
// Serial DAC writer: frames a sample into 16 bits and shifts it out under CS_out.
// Optional DAC_TX_PENDING_EN adds a one-deep request buffer for requests made while busy.
module dac_serial_tx import dac_serial_tx_pkg::*; #(
  parameter pd_mode_t PD_MODE = PD_NORMAL
) (
  input  logic            clock44kHz,
  input  logic            reset,
  dac_serial_tx_if.slave  bus
);
  localparam int CW = $clog2(FRAME_W);

  state_t            state;
  logic [CW-1:0]     cnt;
  logic              load;
  logic              shift;
  logic [DATA_W-1:0] load_data;
`ifdef DAC_TX_PENDING_EN
  logic [DATA_W-1:0] pend;
  logic              pflag;
`endif

  // A request seen in DONE chains straight into the next frame so CS_out
  // is high for a single cycle between back-to-back frames.
  always_comb begin
    load      = 1'b0;
    load_data = bus.dato_in;
    case (state)
      IDLE: load = bus.inicio;
      DONE: begin
`ifdef DAC_TX_PENDING_EN
        load = bus.inicio | pflag;
        if (!bus.inicio) load_data = pend;
`else
        load = bus.inicio;
`endif
      end
      default: load = 1'b0;
    endcase
  end

  assign shift = (state == SHIFT);

  always_ff @(posedge clock44kHz or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      cnt         <= '0;
      bus.CS_out  <= 1'b1;
      bus.ocupado <= 1'b0;
      bus.listo   <= 1'b0;
`ifdef DAC_TX_PENDING_EN
      pend        <= '0;
      pflag       <= 1'b0;
`endif
    end else begin
      bus.listo <= 1'b0;
      case (state)
        IDLE: if (load) begin
          state       <= SHIFT;
          cnt         <= '0;
          bus.CS_out  <= 1'b0;
          bus.ocupado <= 1'b1;
        end
        SHIFT: begin
`ifdef DAC_TX_PENDING_EN
          if (bus.inicio) begin
            pend  <= bus.dato_in;
            pflag <= 1'b1;
          end
`endif
          if (cnt == CW'(FRAME_W-1)) begin
            state      <= DONE;
            bus.CS_out <= 1'b1;
            bus.listo  <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DONE: begin
          if (load) begin
            state      <= SHIFT;
            cnt        <= '0;
            bus.CS_out <= 1'b0;
`ifdef DAC_TX_PENDING_EN
            pflag      <= 1'b0;
`endif
          end else begin
            state       <= IDLE;
            bus.ocupado <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  dac_shift_reg16 #(.W(FRAME_W)) u_sr (
    .clock44kHz (clock44kHz),
    .reset      (reset),
    .load       (load),
    .shift      (shift),
    .din        (build_frame(PD_MODE, load_data)),
    .msb        (bus.datoDAC)
  );
endmodule
